sin_rom_arbiter: RTL and testbench

- Shares one minus_sin_rom instance between two DDS channel requesters using per-channel valid/ready handshakes.
- Grants are round-robin. The arbiter drives the ROM address and clock enable.
- It tracks which channel owns each in-flight lookup across the ROM read latency and returns the ROM word to that channel with a one-cycle response strobe.
- It sits between the channel phase-to-address stages and the shared ROM.

---
 rtl/sin_rom_arbiter.sv | 102 ++++++++++
 tb/tb_sin_rom_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sin_rom_arbiter.sv
// Round-robin share of one minus_sin ROM between two DDS channels.
// Each lookup carries a channel tag across the ROM read latency.
module sin_rom_arbiter #(
  parameter int ROM_ADDR_BITS = 12,
  parameter int ROM_WIDTH     = 18,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     req_valid_0,
  input  logic [ROM_ADDR_BITS-1:0] req_addr_0,
  output logic                     req_ready_0,
  input  logic                     req_valid_1,
  input  logic [ROM_ADDR_BITS-1:0] req_addr_1,
  output logic                     req_ready_1,
  output logic                     rom_ce,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]     rom_data,
  output logic                     rsp_valid_0,
  output logic                     rsp_valid_1,
  output logic [ROM_WIDTH-1:0]     rsp_data,
  output logic                     busy
);

  localparam int L = ROM_LATENCY;

  logic                     last_q;
  logic                     adv_q;
  logic                     gnt_0;
  logic                     gnt_1;
  logic                     gnt;
  logic [ROM_ADDR_BITS-1:0] addr_q;
  logic [L-1:0]             tag_v_q;
  logic [L-1:0]             tag_ch_q;
  logic [L-1:0]             tag_v_d;
  logic [L-1:0]             tag_ch_d;

  // On a tie the channel that did not win last time gets the grant.
  always_comb begin
    gnt_0 = 1'b0;
    gnt_1 = 1'b0;
    if (en && !rst) begin
      unique case (1'b1)
        req_valid_0 && (!req_valid_1 || last_q):
          gnt_0 = 1'b1;
        req_valid_1 && (!req_valid_0 || !last_q):
          gnt_1 = 1'b1;
        default: ;
      endcase
    end
  end

  assign gnt         = gnt_0 | gnt_1;
  assign req_ready_0 = gnt_0;
  assign req_ready_1 = gnt_1;
  assign rom_ce      = en & ~rst;

  always_comb begin
    rom_addr = addr_q;
    unique case (1'b1)
      gnt_0:   rom_addr = req_addr_0;
      gnt_1:   rom_addr = req_addr_1;
      default: ;
    endcase
  end

  if (L == 1) begin : g_one
    assign tag_v_d  = gnt;
    assign tag_ch_d = gnt_1;
  end else begin : g_multi
    assign tag_v_d  = {tag_v_q[L-2:0], gnt};
    assign tag_ch_d = {tag_ch_q[L-2:0], gnt_1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= 1'b1;
      adv_q    <= 1'b0;
      addr_q   <= '0;
      tag_v_q  <= '0;
      tag_ch_q <= '0;
    end else begin
      adv_q <= en;
      if (gnt) begin
        last_q <= gnt_1;
        addr_q <= rom_addr;
      end
      // Tags shift only with the ROM output register.
      if (en) begin
        tag_v_q  <= tag_v_d;
        tag_ch_q <= tag_ch_d;
      end
    end
  end

  assign rsp_valid_0 = tag_v_q[L-1] & ~tag_ch_q[L-1] & adv_q;
  assign rsp_valid_1 = tag_v_q[L-1] &  tag_ch_q[L-1] & adv_q;
  assign rsp_data    = rom_data;
  assign busy        = |tag_v_q;

endmodule

// File: tb/tb_sin_rom_arbiter.sv
// Bench for sin_rom_arbiter: two instances (latency 1 and 3) share
// one stimulus stream; a scoreboard per instance checks responses.
module tb_sin_rom_arbiter;

  localparam int AW = 12;
  localparam int DW = 18;

  typedef struct packed {
    logic          ch;
    logic [DW-1:0] data;
    logic [31:0]   due;
  } sb_t;

  logic          clk = 1'b0;
  logic          rst, en;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;

  logic          g0_n = 1'b0;
  logic          g1_n = 1'b0;
  logic [AW-1:0] a0_n = '0;
  logic [AW-1:0] a1_n = '0;
  logic [31:0]   e_neg = 0;
  logic [31:0]   ecnt = 0;
  logic          ptr = 1'b1;
  logic          fresh = 1'b0;

  int nvec = 0;
  int nerr = 0;
  int pend [2];

  logic [AW-1:0] src0[$];
  logic [AW-1:0] src1[$];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    logic [DW-1:0] t;
    t = {a[5:0], a} ^ (DW'(a) * 18'd37);
    return t;
  endfunction

  task automatic chkw(input string nm, input int inst,
                      input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t",
               nm, inst, act, exp, $time);
    end
  endtask

  // Reference round-robin grant, evaluated from stable inputs.
  initial forever begin
    @(negedge clk);
    if (rst) ptr = 1'b1;
    g0_n  = !rst && en && v0 && (!v1 || ptr);
    g1_n  = !rst && en && v1 && (!v0 || !ptr);
    a0_n  = a0;
    a1_n  = a1;
    e_neg = ecnt;
  end

  initial forever begin
    @(posedge clk);
    if (g0_n) ptr = 1'b0;
    else if (g1_n) ptr = 1'b1;
    fresh = en && !rst;
    if (fresh) ecnt++;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 1 : 3;

    logic          rdy0, rdy1, ce, rv0, rv1, bsy;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata, rsp;
    logic [DW-1:0] pipe [L];
    sb_t           q[$];
    logic          tail = 1'b0;
    logic          ex;

    sin_rom_arbiter #(
      .ROM_ADDR_BITS(AW),
      .ROM_WIDTH(DW),
      .ROM_LATENCY(L)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .en(en),
      .req_valid_0(v0),
      .req_addr_0(a0),
      .req_ready_0(rdy0),
      .req_valid_1(v1),
      .req_addr_1(a1),
      .req_ready_1(rdy1),
      .rom_ce(ce),
      .rom_addr(raddr),
      .rom_data(rdata),
      .rsp_valid_0(rv0),
      .rsp_valid_1(rv1),
      .rsp_data(rsp),
      .busy(bsy)
    );

    always @(posedge clk) begin
      if (ce) begin
        pipe[0] <= rom_f(raddr);
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
      end
    end
    assign rdata = pipe[L-1];

    // Expected responses are queued as requests are accepted.
    initial forever begin
      @(posedge clk);
      if (g0_n) begin
        q.push_back('{ch: 1'b0, data: rom_f(a0_n), due: e_neg + L});
        pend[gi]++;
      end
      if (g1_n) begin
        q.push_back('{ch: 1'b1, data: rom_f(a1_n), due: e_neg + L});
        pend[gi]++;
      end
      if (en && !rst) tail = 1'b0;
    end

    initial forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        q.delete();
        pend[gi] = 0;
        tail = 1'b0;
      end
      chkw("req_ready_0", gi, 32'(rdy0), 32'(g0_n));
      chkw("req_ready_1", gi, 32'(rdy1), 32'(g1_n));
      chkw("rom_ce", gi, 32'(ce), 32'(en && !rst));
      if (g0_n) chkw("rom_addr", gi, 32'(raddr), 32'(a0_n));
      if (g1_n) chkw("rom_addr", gi, 32'(raddr), 32'(a1_n));
      chkw("busy", gi, 32'(bsy), 32'(q.size() != 0 || tail));
      ex = fresh && q.size() != 0 && q[0].due == ecnt;
      chkw("rsp_valid", gi, 32'(rv0 | rv1), 32'(ex));
      if (ex) begin
        chkw("rsp_valid_0", gi, 32'(rv0), 32'(!q[0].ch));
        chkw("rsp_valid_1", gi, 32'(rv1), 32'(q[0].ch));
        chkw("rsp_data", gi, 32'(rsp), 32'(q[0].data));
        void'(q.pop_front());
        pend[gi]--;
        tail = 1'b1;
      end
    end
  end

  // Requesters hold valid/addr until the reference model grants them.
  task automatic cyc(input logic en_v, input logic rst_v, input bit rnd);
    @(posedge clk);
    if (g0_n) void'(src0.pop_front());
    if (g1_n) void'(src1.pop_front());
    #1;
    rst = rst_v;
    en  = en_v;
    if (!(v0 && !g0_n)) begin
      if (src0.size() != 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
        v0 = 1'b1;
        a0 = src0[0];
      end else begin
        v0 = 1'b0;
      end
    end
    if (!(v1 && !g1_n)) begin
      if (src1.size() != 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
        v1 = 1'b1;
        a1 = src1[0];
      end else begin
        v1 = 1'b0;
      end
    end
  endtask

  initial begin
    int guard;
    pend[0] = 0;
    pend[1] = 0;
    rst = 1'b1;
    en  = 1'b0;
    v0  = 1'b0;
    v1  = 1'b0;
    a0  = '0;
    a1  = '0;

    repeat (2) cyc(1'b0, 1'b1, 1'b0);
    repeat (10) cyc(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) src0.push_back(AW'(i));
    repeat (18) cyc(1'b1, 1'b0, 1'b0);

    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      src0.push_back(AW'(i));
      src1.push_back(AW'(1024 + i));
    end
    repeat (12) cyc(1'b1, 1'b0, 1'b0);

    src1.push_back(AW'(1024));
    cyc(1'b1, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    repeat (6) cyc(1'b1, 1'b0, 1'b0);

    src0.push_back(AW'(5));
    src0.push_back(AW'(6));
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    src1.push_back(AW'(7));
    repeat (8) cyc(1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      src0.push_back(AW'($urandom_range(0, 4095)));
      src1.push_back(AW'($urandom_range(0, 4095)));
    end
    for (int i = 0; i < 1000; i++)
      cyc($urandom_range(0, 9) != 0, 1'b0, 1'b1);

    guard = 0;
    while ((src0.size() != 0 || src1.size() != 0) && guard < 3000) begin
      cyc(1'b1, 1'b0, 1'b0);
      guard++;
    end
    chkw("drain_src", 0, 32'(src0.size() + src1.size()), 32'd0);
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    chkw("pending", 0, 32'(pend[0]), 32'd0);
    chkw("pending", 1, 32'(pend[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
